// File: rtl/rs_ff_exerciser.sv
// Drives a 6-step set/reset/hold sequence into an external RS flip-flop and checks
// the synchronised q/qnot response, reporting pass, error count and first failing step.
//
// state  | meaning
// IDLE   | outputs low, results held, waiting for start
// RUN    | stepping through the stimulus table, checking each step at end of hold
// FINISH | one-cycle done pulse, results published
module rs_ff_exerciser #(
    parameter int HOLD_CYCLES   = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int CHECK_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       q_in,
    input  logic       qnot_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [2:0] first_fail,
    output logic [2:0] step_idx
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [2:0] LAST_STEP = 3'd5;
    localparam logic [2:0] NO_FAIL = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t                 state;
    logic [CW-1:0]          hold_cnt;
    logic [SYNC_STAGES-1:0] q_sync;
    logic [SYNC_STAGES-1:0] qnot_sync;
    logic                   step_check;
    logic                   step_err;
    logic [2:0]             err_next;

    // {a, b} stimulus per step
    function automatic logic [1:0] step_ab(input logic [2:0] idx);
        case (idx)
            3'd0:    step_ab = 2'b01;
            3'd1:    step_ab = 2'b00;
            3'd2:    step_ab = 2'b10;
            3'd3:    step_ab = 2'b00;
            3'd4:    step_ab = 2'b11;
            default: step_ab = 2'b01;
        endcase
    endfunction

    // expected {q, qnot} per step
    function automatic logic [1:0] step_exp(input logic [2:0] idx);
        case (idx)
            3'd0:    step_exp = 2'b01;
            3'd1:    step_exp = 2'b01;
            3'd2:    step_exp = 2'b10;
            3'd3:    step_exp = 2'b10;
            3'd4:    step_exp = 2'b00;
            default: step_exp = 2'b01;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync    <= '0;
            qnot_sync <= '0;
        end else begin
            q_sync    <= {q_sync[SYNC_STAGES-2:0], q_in};
            qnot_sync <= {qnot_sync[SYNC_STAGES-2:0], qnot_in};
        end
    end

    always_comb begin
        step_check = (CHECK_ILLEGAL != 0) || (step_idx != 3'd4);
        step_err   = step_check &&
                     ({q_sync[SYNC_STAGES-1], qnot_sync[SYNC_STAGES-1]} != step_exp(step_idx));
        err_next   = err_count + {2'b00, step_err};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            first_fail <= NO_FAIL;
            step_idx   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    if (start) begin
                        state          <= RUN;
                        busy           <= 1'b1;
                        step_idx       <= 3'd0;
                        hold_cnt       <= '0;
                        err_count      <= 3'd0;
                        first_fail     <= NO_FAIL;
                        pass           <= 1'b0;
                        {a_out, b_out} <= step_ab(3'd0);
                    end
                end
                RUN: begin
                    if (hold_cnt == HOLD_LAST) begin
                        err_count <= err_next;
                        if (step_err && first_fail == NO_FAIL)
                            first_fail <= step_idx;
                        if (step_idx < LAST_STEP) begin
                            step_idx       <= step_idx + 3'd1;
                            {a_out, b_out} <= step_ab(step_idx + 3'd1);
                            hold_cnt       <= '0;
                        end else begin
                            // pass must include the verdict of the step checked on this edge
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (err_next == 3'd0);
                            a_out <= 1'b0;
                            b_out <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_ff_exerciser.sv
// Bench for rs_ff_exerciser: two instances (illegal-step check on and off) share the
// q/qnot stimulus, which comes either from a scripted per-step pattern or an ideal RS model.
module tb_rs_ff_exerciser;

    localparam int H = 8;

    typedef logic [5:0][1:0] pat_t;
    typedef struct {
        pat_t pat;
        int   err1;
        int   ff1;
        int   err0;
        int   ff0;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       q_in, qnot_in;
    logic       a_out, b_out, busy, done, pass;
    logic [2:0] err_count, first_fail, step_idx;
    logic       a_out0, b_out0, busy0, done0, pass0;
    logic [2:0] err_count0, first_fail0, step_idx0;

    logic       mode;
    logic       tq, tqn;
    logic       mq = 1'b0;
    logic       mqn = 1'b1;
    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         done_cnt0 = 0;
    logic [1:0] ab_tab [6];
    logic [1:0] exp_tab [6];
    vec_t       vecs [6];

    always #5 clk = ~clk;

    assign q_in    = mode ? mq : tq;
    assign qnot_in = mode ? mqn : tqn;

    // Ideal NOR RS latch behaviour: set, reset, both-high forces 00, both-low holds
    always @(a_out or b_out) begin
        if (a_out && !b_out)      begin mq = 1'b1; mqn = 1'b0; end
        else if (!a_out && b_out) begin mq = 1'b0; mqn = 1'b1; end
        else if (a_out && b_out)  begin mq = 1'b0; mqn = 1'b0; end
    end

    always @(negedge clk) begin
        if (done)  done_cnt++;
        if (done0) done_cnt0++;
    end

    rs_ff_exerciser #(.HOLD_CYCLES(H), .SYNC_STAGES(2), .CHECK_ILLEGAL(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q_in(q_in), .qnot_in(qnot_in),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail(first_fail), .step_idx(step_idx)
    );

    rs_ff_exerciser #(.HOLD_CYCLES(H), .SYNC_STAGES(2), .CHECK_ILLEGAL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .q_in(q_in), .qnot_in(qnot_in),
        .a_out(a_out0), .b_out(b_out0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err_count0), .first_fail(first_fail0), .step_idx(step_idx0)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference verdict from the step rules: count steps whose response differs from expected
    task automatic ref_eval(input pat_t pat, input bit ci, output int err, output int ff);
        err = 0;
        ff  = 7;
        for (int k = 0; k < 6; k++) begin
            if ((ci || k != 4) && pat[k] != exp_tab[k]) begin
                err++;
                if (ff == 7) ff = k;
            end
        end
    endtask

    task automatic run_seq(input pat_t pat, input logic [5:0] extra);
        @(negedge clk);
        {tq, tqn} = pat[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on", busy, 1);
        chk("err_clr", err_count, 0);
        chk("ff_clr", first_fail, 7);
        chk("pass_clr", pass, 0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) {tq, tqn} = pat[k];
            chk($sformatf("step_idx%0d", k), step_idx, k);
            chk($sformatf("step_idx0_%0d", k), step_idx0, k);
            chk($sformatf("ab_step%0d", k), {a_out, b_out}, ab_tab[k]);
            if (extra[k]) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (H - 1) @(negedge clk);
        end
        chk("done_hi", done, 1);
        chk("done0_hi", done0, 1);
        chk("busy_off", busy, 0);
        chk("busy0_off", busy0, 0);
        chk("ab_finish", {a_out, b_out, a_out0, b_out0}, 0);
        @(negedge clk);
        chk("done_lo", done, 0);
    endtask

    initial begin
        pat_t ideal, p;
        int   cyc, dc, e1, f1, e0, f0;

        ab_tab  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01};
        exp_tab = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01};
        for (int k = 0; k < 6; k++) ideal[k] = exp_tab[k];

        vecs[0] = '{ideal, 0, 7, 0, 7};
        for (int k = 0; k < 6; k++) p[k] = 2'b01;
        vecs[1] = '{p, 3, 2, 2, 2};
        for (int k = 0; k < 6; k++) p[k] = 2'b11;
        vecs[2] = '{p, 6, 0, 5, 0};
        for (int k = 0; k < 6; k++) p[k] = 2'b00;
        vecs[3] = '{p, 5, 0, 5, 0};
        p = ideal; p[5] = 2'b10;
        vecs[4] = '{p, 1, 5, 1, 5};
        p = ideal; p[4] = 2'b01;
        vecs[5] = '{p, 1, 4, 0, 7};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; tq = 1'b0; tqn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ab", {a_out, b_out}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_ff", first_fail, 7);
        chk("rst_step", step_idx, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ideal latch, latency from start edge to done
        mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk("t1_busy", busy, 1);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("t1_latency", cyc, 49);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_count, 0);
        chk("t1_ff", first_fail, 7);
        chk("t1_pass0", pass0, 1);
        @(negedge clk);
        chk("t1_done_lo", done, 0);

        // Scripted per-step responses
        mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i].pat, 6'b0);
            chk($sformatf("v%0d_err", i), err_count, vecs[i].err1);
            chk($sformatf("v%0d_ff", i), first_fail, vecs[i].ff1);
            chk($sformatf("v%0d_pass", i), pass, vecs[i].err1 == 0);
            chk($sformatf("v%0d_err0", i), err_count0, vecs[i].err0);
            chk($sformatf("v%0d_ff0", i), first_fail0, vecs[i].ff0);
            chk($sformatf("v%0d_pass0", i), pass0, vecs[i].err0 == 0);
        end
        repeat (10) @(negedge clk);
        chk("hold_err", err_count, vecs[5].err1);
        chk("hold_ff", first_fail, vecs[5].ff1);

        // Reset asserted during step 3
        mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * H + 3) @(negedge clk);
        chk("t4_in_step3", step_idx, 3);
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("t4_ab", {a_out, b_out}, 0);
        chk("t4_busy", busy, 0);
        chk("t4_err", err_count, 0);
        chk("t4_ff", first_fail, 7);
        chk("t4_step", step_idx, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("t4_no_done", done_cnt, dc);
        run_seq(ideal, 6'b0);
        chk("t4_rerun_pass", pass, 1);

        // Extra start pulses mid-run are ignored
        dc = done_cnt;
        run_seq(ideal, 6'b100010);
        chk("t5_one_done", done_cnt, dc + 1);
        chk("t5_pass", pass, 1);

        // Failing run then a clean run
        mode = 1'b0;
        run_seq(vecs[1].pat, 6'b0);
        chk("t6_fail_err", err_count, 3);
        mode = 1'b1;
        run_seq(ideal, 6'b0);
        chk("t6_pass", pass, 1);
        chk("t6_err", err_count, 0);

        // Random per-step responses against the reference verdict
        mode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 6; k++) p[k] = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_seq(p, 6'b0);
            ref_eval(p, 1'b1, e1, f1);
            ref_eval(p, 1'b0, e0, f0);
            chk($sformatf("r%0d_err", i), err_count, e1);
            chk($sformatf("r%0d_ff", i), first_fail, f1);
            chk($sformatf("r%0d_pass", i), pass, e1 == 0);
            chk($sformatf("r%0d_err0", i), err_count0, e0);
            chk($sformatf("r%0d_ff0", i), first_fail0, f0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rs_ff_exerciser.md
Name: rs_ff_exerciser

Overview:
Hardware stimulus generator and response checker for the RS flip-flop exercise: it is the on-FPGA driver that owns the flip-flop's a/b inputs and reads back q/qnot.
- Runs a fixed 6-step set/reset/hold sequence and synchronises the flip-flop outputs, which are asynchronous to clk.
- Compares each step against the expected value and reports pass/fail, error count and the first failing step.
- Sits between the board's start button (already debounced) and the flip-flop instance; results drive LEDs.

Parameters:
HOLD_CYCLES, 8, clk cycles each stimulus step is held; must be >= SYNC_STAGES+2
SYNC_STAGES, 2, depth of the q/qnot synchroniser chain (>=2)
CHECK_ILLEGAL, 1, 1 = check NOR behaviour (q=0, qnot=0) on a=b=1 step; 0 = skip that step's check

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle start request, synchronous
q_in  input  1  flip-flop q, asynchronous
qnot_in  input  1  flip-flop qnot, asynchronous
a_out  output  1  flip-flop a (set) input
b_out  output  1  flip-flop b (reset) input
busy  output  1  sequence in progress
done  output  1  one-cycle pulse when sequence completes
pass  output  1  1 = last run had zero errors; held until next start
err_count  output  3  mismatching steps in last run (0..6)
first_fail  output  3  index of first failing step; 7 = none
step_idx  output  3  current step index

Behaviour:
- Reset (async assert, sync deassert on clk): a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=7, step_idx=0, state IDLE, synchroniser flops=0.
- Step table, as (a,b) -> expected (q,qnot):
  - 0: (0,1) -> (0,1) reset
  - 1: (0,0) -> (0,1) hold
  - 2: (1,0) -> (1,0) set
  - 3: (0,0) -> (1,0) hold
  - 4: (1,1) -> (0,0) illegal, checked only if CHECK_ILLEGAL=1
  - 5: (0,1) -> (0,1) recovery
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - a_out=b_out=0.
  - start=1 at edge N -> at edge N: RUN, busy=1, step_idx=0, hold_cnt=0, err_count=0, first_fail=7, pass=0, and step 0 values on a_out/b_out.
  - Step 0 stimulus is therefore visible in the cycle after edge N.
- RUN:
  - a_out/b_out come from registers loaded from the table at each step entry.
  - hold_cnt increments every cycle.
  - On the cycle with hold_cnt==HOLD_CYCLES-1, the synchronised q/qnot are compared to expected.
  - On mismatch: err_count+1; first_fail=step_idx if first_fail==7.
  - Same edge: if step_idx<5, advance step_idx, reload a/b, hold_cnt=0; else go to FINISH.
- FINISH: one cycle. done=1, busy=0, pass=(err_count==0), a_out=b_out=0, then IDLE.
- Latency: start edge N -> done high in cycle after edge N+6*HOLD_CYCLES (49 cycles for default).
- start while busy or in FINISH: ignored, no restart.
- Results (pass, err_count, first_fail) hold in IDLE until the next accepted start.
- Synchroniser: SYNC_STAGES flops per input, no reset dependency beyond rst_n clearing them to 0. Compare only the final stage.
- rst_n asserted mid-run: immediate return to reset values, a_out=b_out=0; no done pulse.
- Compare uses registered equality on both q and qnot, so qnot==q on a legal step counts as an error.

Test Plan:
1. Ideal NOR RS model on a_out/b_out, start pulse at cycle 5 -> busy 1 from cycle 6; done pulse after 48 cycles of RUN; pass=1, err_count=0, first_fail=7.
2. q_in tied 0, qnot_in tied 1, CHECK_ILLEGAL=1 -> fails on steps 2, 3, 4; err_count=3, first_fail=2, pass=0.
3. Same stuck inputs, CHECK_ILLEGAL=0 -> err_count=2, first_fail=2.
4. Ideal model; rst_n low for 3 cycles during step 3 -> a_out=b_out=0, busy=0, err_count=0, first_fail=7 immediately; no done. A new start gives pass=1.
5. Extra start pulses at steps 1 and 5 -> step_idx sequence 0..5 uninterrupted; a single done pulse.
6. Run 2 fails; then model fixed and start issued -> err_count cleared on the start edge; final pass=1.
